multicycle_main_fsm: RTL and testbench

Main control FSM for the multicycle variant of the RV32I core. It sequences the shared ALU, memory port, IR/PC and register-file write enables across Fetch/Decode/Execute/Memory/Writeback states. It drives the 2-bit ALUOp consumed by the existing ALU control decoder. It also counts retired instructions and flags unsupported opcodes.

---
 rtl/multicycle_main_fsm.sv | 166 ++++++++++++++++
 tb/tb_multicycle_main_fsm.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_fsm.sv
// rtl/multicycle_main_fsm.sv - main control FSM for the multicycle RV32I core
// Sequences ALU, memory port, IR/PC and register-file enables; counts retired instructions.
module multicycle_main_fsm #(
  parameter int CNT_W        = 32,
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             RegWrite,
  output logic             illegal,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;
  logic             pc_write, ir_write, mem_write, reg_write, illegal_raw;
  logic             unused_funct3;

  // Only beq/bne are distinguished; the upper funct3 bits are deliberately ignored.
  assign unused_funct3 = ^funct3[2:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d     = FETCH;
    retire      = 1'b0;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    illegal_raw = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    case (state_q)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECR;
          OP_ITYPE:          state_d = EXECI;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          default:           state_d = ILLEGAL;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        retire    = mem_ready;
        state_d   = mem_ready ? FETCH : MEMWRITE;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        state_d = ALUWB;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      BRANCH: begin
        ALUSrcA  = 2'b10;
        ALUOp    = 2'b01;
        pc_write = zero ^ funct3[0];
        retire   = 1'b1;
      end
      JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pc_write = 1'b1;
        state_d  = ALUWB;
      end
      ILLEGAL: begin
        illegal_raw = 1'b1;
        state_d     = ILLEGAL_HALT ? ILLEGAL : FETCH;
      end
      default: state_d = FETCH;
    endcase
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  // Reset gates every write enable so an abandoned instruction leaves no side effects.
  assign PCWrite  = pc_write    & ~reset;
  assign IRWrite  = ir_write    & ~reset;
  assign MemWrite = mem_write   & ~reset;
  assign RegWrite = reg_write   & ~reset;
  assign illegal  = illegal_raw & ~reset;
  assign state_o  = state_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// tb/tb_multicycle_main_fsm.sv - self-checking bench for multicycle_main_fsm
// Per-instruction expected state traces are built from the instruction class and wait counts.
module tb_multicycle_main_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;

  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [3:0]  state_o;
  logic [31:0] instret;

  logic        h_PCWrite, h_AdrSrc, h_MemWrite, h_IRWrite, h_RegWrite, h_illegal;
  logic [1:0]  h_ResultSrc, h_ALUSrcA, h_ALUSrcB, h_ALUOp;
  logic [3:0]  h_state_o;
  logic [2:0]  h_instret;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_instret = 0;

  multicycle_main_fsm #(.CNT_W(32), .ILLEGAL_HALT(1'b0)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .RegWrite(RegWrite), .illegal(illegal), .state_o(state_o), .instret(instret)
  );

  multicycle_main_fsm #(.CNT_W(3), .ILLEGAL_HALT(1'b1)) dut_halt (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(h_PCWrite), .AdrSrc(h_AdrSrc), .MemWrite(h_MemWrite), .IRWrite(h_IRWrite),
    .ResultSrc(h_ResultSrc), .ALUSrcA(h_ALUSrcA), .ALUSrcB(h_ALUSrcB), .ALUOp(h_ALUOp),
    .RegWrite(h_RegWrite), .illegal(h_illegal), .state_o(h_state_o), .instret(h_instret)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Expected Moore outputs per state:
  // {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, MemWrite, RegWrite, illegal}
  function automatic logic [11:0] ctrl(input int s);
    case (s)
      0:  return {1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000};
      1:  return {1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000};
      2:  return {1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000};
      3:  return {1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
      4:  return {1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b010};
      5:  return {1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b100};
      6:  return {1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000};
      7:  return {1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 3'b000};
      8:  return {1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010};
      9:  return {1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 3'b000};
      10: return {1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000};
      11: return {1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001};
      default: return 12'h000;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    op = 7'b0110011;
    funct3 = 3'b000;
    zero = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (state_o !== 4'd0 || {PCWrite, IRWrite, MemWrite, RegWrite, illegal} !== 5'b0 || instret !== 32'd0) begin
        errors++;
        $display("FAIL reset: state=%0d enables=%b instret=%0d, want state=0 enables=00000 instret=0",
                 state_o, {PCWrite, IRWrite, MemWrite, RegWrite, illegal}, instret);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_instret = 0;
  endtask

  // cls: 0 lw, 1 sw, 2 R, 3 I, 4 branch, 5 jal, 6 illegal
  // wf/wm: cycles of mem_ready low in FETCH / in the memory access state
  task automatic do_instr(input int cls, input int wf, input int wm, input logic z, input logic [2:0] f3);
    int          st[$];
    logic        rdy[$];
    logic [6:0]  opv;
    logic [6:0]  ill_ops[6];
    logic [11:0] expc, obsc;
    logic [1:0]  exp_pi, obs_pi;
    logic        exp_pc;
    ill_ops = '{7'b1110011, 7'b0110111, 7'b0010111, 7'b1100111, 7'b0000000, 7'b1111111};
    opv = 7'b0110011;
    for (int i = 0; i < wf; i++) begin st.push_back(0); rdy.push_back(1'b0); end
    st.push_back(0); rdy.push_back(1'b1);
    st.push_back(1); rdy.push_back(1'($urandom));
    case (cls)
      0: begin
        opv = 7'b0000011;
        st.push_back(2); rdy.push_back(1'($urandom));
        for (int i = 0; i < wm; i++) begin st.push_back(3); rdy.push_back(1'b0); end
        st.push_back(3); rdy.push_back(1'b1);
        st.push_back(4); rdy.push_back(1'($urandom));
      end
      1: begin
        opv = 7'b0100011;
        st.push_back(2); rdy.push_back(1'($urandom));
        for (int i = 0; i < wm; i++) begin st.push_back(5); rdy.push_back(1'b0); end
        st.push_back(5); rdy.push_back(1'b1);
      end
      2: begin opv = 7'b0110011; st.push_back(6); rdy.push_back(1'($urandom)); st.push_back(8); rdy.push_back(1'($urandom)); end
      3: begin opv = 7'b0010011; st.push_back(7); rdy.push_back(1'($urandom)); st.push_back(8); rdy.push_back(1'($urandom)); end
      4: begin opv = 7'b1100011; st.push_back(9); rdy.push_back(1'($urandom)); end
      5: begin opv = 7'b1101111; st.push_back(10); rdy.push_back(1'($urandom)); st.push_back(8); rdy.push_back(1'($urandom)); end
      default: begin opv = ill_ops[$urandom_range(0, 5)]; st.push_back(11); rdy.push_back(1'($urandom)); end
    endcase
    for (int k = 0; k < st.size(); k++) begin
      op = opv; funct3 = f3; zero = z; mem_ready = rdy[k];
      @(negedge clk);
      expc = ctrl(st[k]);
      obsc = {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, MemWrite, RegWrite, illegal};
      exp_pc = (st[k] == 0) ? rdy[k] : (st[k] == 9) ? (z ^ f3[0]) : (st[k] == 10);
      exp_pi = {exp_pc, (st[k] == 0) && rdy[k]};
      obs_pi = {PCWrite, IRWrite};
      checks++;
      if (state_o !== 4'(st[k])) begin
        errors++;
        $display("FAIL state cls=%0d cyc=%0d: got %0d want %0d", cls, k, state_o, st[k]);
      end
      checks++;
      if (obsc !== expc) begin
        errors++;
        $display("FAIL ctrl cls=%0d cyc=%0d state=%0d: got %b want %b", cls, k, st[k], obsc, expc);
      end
      checks++;
      if (obs_pi !== exp_pi) begin
        errors++;
        $display("FAIL pc_ir cls=%0d cyc=%0d state=%0d: got %b want %b", cls, k, st[k], obs_pi, exp_pi);
      end
      checks++;
      if (instret !== exp_instret) begin
        errors++;
        $display("FAIL instret cls=%0d cyc=%0d: got %0d want %0d", cls, k, instret, exp_instret);
      end
      @(posedge clk);
      #1;
    end
    if (cls != 6) exp_instret++;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_rtype();
    do_reset();
    do_instr(2, 0, 0, 1'b0, 3'b000);
    do_instr(3, 1, 0, 1'b0, 3'b000);
    @(negedge clk);
    checks++;
    if (state_o !== 4'd0 || instret !== 32'd2) begin
      errors++;
      $display("FAIL rtype_after: state=%0d instret=%0d, want 0 and 2", state_o, instret);
    end
    @(posedge clk); #1;
    do_reset();
  endtask

  task automatic test_lw_wait();
    do_reset();
    do_instr(0, 2, 3, 1'b0, 3'b010);
  endtask

  task automatic test_sw_wait();
    do_reset();
    do_instr(1, 0, 2, 1'b0, 3'b010);
  endtask

  task automatic test_branches();
    do_reset();
    do_instr(4, 0, 0, 1'b1, 3'b000);
    do_instr(4, 0, 0, 1'b0, 3'b000);
    do_instr(4, 0, 0, 1'b0, 3'b001);
    do_instr(4, 1, 0, 1'b1, 3'b001);
    do_instr(4, 0, 0, 1'b1, 3'b100);
  endtask

  task automatic test_jal();
    do_reset();
    do_instr(5, 0, 0, 1'b0, 3'b000);
  endtask

  task automatic test_illegal();
    do_reset();
    do_instr(2, 0, 0, 1'b0, 3'b000);
    do_instr(6, 0, 0, 1'b0, 3'b000);
    do_instr(2, 0, 0, 1'b0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (h_state_o !== 4'd11 || h_illegal !== 1'b1 || h_instret !== 3'd1) begin
        errors++;
        $display("FAIL halt_hold: state=%0d illegal=%b instret=%0d, want 11 1 1", h_state_o, h_illegal, h_instret);
      end
      @(posedge clk); #1;
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (h_state_o !== 4'd0 || h_illegal !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset: state=%0d illegal=%b, want 0 0", h_state_o, h_illegal);
    end
    @(posedge clk); #1;
    do_reset();
  endtask

  task automatic test_reset_mid();
    do_reset();
    op = 7'b0000011;
    mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (state_o !== 4'd3) begin
      errors++;
      $display("FAIL mid_memread: state=%0d want 3", state_o);
    end
    reset = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (RegWrite !== 1'b0 || PCWrite !== 1'b0) begin
      errors++;
      $display("FAIL mid_gate: RegWrite=%b PCWrite=%b want 0 0", RegWrite, PCWrite);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (state_o !== 4'd0 || RegWrite !== 1'b0 || instret !== 32'd0) begin
      errors++;
      $display("FAIL mid_after: state=%0d RegWrite=%b instret=%0d want 0 0 0", state_o, RegWrite, instret);
    end
    @(posedge clk); #1;
    do_reset();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 10; i++) do_instr(2, 0, 0, 1'b0, 3'b000);
    @(negedge clk);
    checks++;
    if (h_instret !== 3'd2) begin
      errors++;
      $display("FAIL wrap: got %0d want 2", h_instret);
    end
    @(posedge clk); #1;
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 60; i++)
      do_instr($urandom_range(0, 6), $urandom_range(0, 2), $urandom_range(0, 3),
               1'($urandom), 3'($urandom));
  endtask

  initial begin
    reset = 1'b1; op = 7'b0; funct3 = 3'b0; zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw_wait();
    test_branches();
    test_jal();
    test_illegal();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
